// File: rtl/tune_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tune_ctrl_if                                                       |
// | Button inputs and phase-increment outputs of the tuning controller |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface tune_ctrl_if #(
  parameter int unsigned PHASE_W = 40
);
  logic               btn_up;
  logic               btn_down;
  logic               btn_right;
  logic               btn_left;
  logic               btn_preset;
  logic [PHASE_W-1:0] phase_inc;
  logic               inc_update;
  logic [1:0]         preset_idx;
  logic               at_limit;

  modport master (
    output btn_up, btn_down, btn_right, btn_left, btn_preset,
    input  phase_inc, inc_update, preset_idx, at_limit
  );

  modport slave (
    input  btn_up, btn_down, btn_right, btn_left, btn_preset,
    output phase_inc, inc_update, preset_idx, at_limit
  );
endinterface
`default_nettype wire

// File: rtl/tune_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tune_ctrl                                                          |
// | NCO phase-increment tuning controller: debounced buttons, repeat,  |
// | band limits and presets. Define TUNE_WRAP_EN for wrap at the band  |
// | edges instead of clamping.                                         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tune_ctrl #(
  parameter int unsigned        PHASE_W       = 40,
  parameter int unsigned        DEBOUNCE_CYC  = 1000000,
  parameter int unsigned        REPEAT_DELAY  = 50000000,
  parameter int unsigned        REPEAT_PERIOD = 10000000,
  parameter logic [PHASE_W-1:0] FINE_STEP     = 40'h110c6f7,
  parameter logic [PHASE_W-1:0] COARSE_STEP   = 40'h1346dc5d,
  parameter logic [PHASE_W-1:0] MIN_INC       = 40'h0,
  parameter logic [PHASE_W-1:0] MAX_INC       = 40'h47ae147ae1,
  parameter logic [PHASE_W-1:0] RESET_INC     = 40'h2656abde3,
  parameter logic [PHASE_W-1:0] PRESET0       = 40'h2656abde3,
  parameter logic [PHASE_W-1:0] PRESET1       = 40'h1e98dcdb3,
  parameter logic [PHASE_W-1:0] PRESET2       = 40'h41fc8f323,
  parameter logic [PHASE_W-1:0] PRESET3       = 40'h17f62b6ae
) (
  input  logic      CLK,
  input  logic      RST,
  tune_ctrl_if.slave bus
);

  localparam int c_db_w    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rpt_w   = (c_rpt_max > 1) ? $clog2(c_rpt_max) : 1;
  localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [c_rpt_w-1:0] c_dly_last = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_per_last = c_rpt_w'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Bit order: 0 up, 1 down, 2 right, 3 left, 4 preset
  logic [4:0]         w_raw, r_sync1, r_sync2, w_deb, r_deb_prev, w_rise;
  logic [1:0]         w_fire, w_dir_up;
  logic [PHASE_W-1:0] r_phase, w_step, w_step_val, w_preset_val, w_next;
  logic [PHASE_W:0]   w_sum, w_floor;
  logic [1:0]         r_idx, w_idx_next;
  logic               r_upd, r_lim, w_up, w_wrap, w_pulse;

  assign w_raw  = {bus.btn_preset, bus.btn_left, bus.btn_right, bus.btn_down, bus.btn_up};
  assign w_rise = w_deb & ~r_deb_prev;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      logic [c_db_w-1:0] r_cnt;
      logic              r_level;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2[gi] != r_level) begin
          if (r_cnt == c_db_last) begin
            r_level <= r_sync2[gi];
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_db_w'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
      assign w_deb[gi] = r_level;
    end

    // Group 0 is coarse (up/down), group 1 is fine (right/left)
    for (genvar gi = 0; gi < 2; gi++) begin : g_grp
      state_t             r_state;
      logic [c_rpt_w-1:0] r_cnt;
      logic               w_a, w_b, w_single, w_edge, w_fire_l;
      assign w_a      = w_deb[2*gi];
      assign w_b      = w_deb[2*gi+1];
      assign w_single = w_a ^ w_b;
      assign w_edge   = (w_rise[2*gi] & ~w_b) | (w_rise[2*gi+1] & ~w_a);
      assign w_fire_l = (r_state == S_IDLE)   ? w_edge :
                        (r_state == S_DELAY)  ? (w_single && (r_cnt == c_dly_last)) :
                        (r_state == S_REPEAT) ? (w_single && (r_cnt == c_per_last)) : 1'b0;
      assign w_fire[gi]   = w_fire_l;
      assign w_dir_up[gi] = w_a;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              r_cnt <= '0;
              if (w_edge) r_state <= S_DELAY;
            end
            S_DELAY: begin
              if (!w_single) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
              end else if (r_cnt == c_dly_last) begin
                r_state <= S_REPEAT;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + c_rpt_w'(1);
              end
            end
            S_REPEAT: begin
              if (!w_single) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
              end else if (r_cnt == c_per_last) begin
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + c_rpt_w'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Coarse outranks fine when both groups fire together
  always_comb begin
    w_step     = w_fire[0] ? COARSE_STEP : FINE_STEP;
    w_up       = w_fire[0] ? w_dir_up[0] : w_dir_up[1];
    w_sum      = {1'b0, r_phase} + {1'b0, w_step};
    w_floor    = {1'b0, MIN_INC} + {1'b0, w_step};
    w_step_val = r_phase;
    w_wrap     = 1'b0;
    if (w_up) begin
      if (w_sum > {1'b0, MAX_INC}) begin
`ifdef TUNE_WRAP_EN
        w_step_val = MIN_INC;
        w_wrap     = 1'b1;
`else
        w_step_val = MAX_INC;
`endif
      end else begin
        w_step_val = w_sum[PHASE_W-1:0];
      end
    end else begin
      if ({1'b0, r_phase} < w_floor) begin
`ifdef TUNE_WRAP_EN
        w_step_val = MAX_INC;
        w_wrap     = 1'b1;
`else
        w_step_val = MIN_INC;
`endif
      end else begin
        w_step_val = r_phase - w_step;
      end
    end
  end

  assign w_idx_next = r_idx + 2'd1;

  always_comb begin
    case (w_idx_next)
      2'd0:    w_preset_val = PRESET0;
      2'd1:    w_preset_val = PRESET1;
      2'd2:    w_preset_val = PRESET2;
      default: w_preset_val = PRESET3;
    endcase
  end

  always_comb begin
    w_next  = r_phase;
    w_pulse = 1'b0;
    if (w_rise[4]) begin
      w_next  = w_preset_val;
      w_pulse = (w_preset_val != r_phase);
    end else if (|w_fire) begin
      w_next  = w_step_val;
      w_pulse = (w_step_val != r_phase) | w_wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb_prev <= '0;
      r_phase    <= RESET_INC;
      r_upd      <= 1'b0;
      r_idx      <= 2'd0;
      r_lim      <= (RESET_INC == MIN_INC) || (RESET_INC == MAX_INC);
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= w_deb;
      r_phase    <= w_next;
      r_upd      <= w_pulse;
      r_lim      <= (w_next == MIN_INC) || (w_next == MAX_INC);
      if (w_rise[4]) r_idx <= w_idx_next;
    end
  end

  assign bus.phase_inc  = r_phase;
  assign bus.inc_update = r_upd;
  assign bus.preset_idx = r_idx;
  assign bus.at_limit   = r_lim;

endmodule
`default_nettype wire
